membus_mmio_ctrl: RTL and testbench



---
 rtl/membus_mmio_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_membus_mmio_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/membus_mmio_ctrl.sv
// Memory-map controller: mirrored RAM, ROM window, MMIO page (LED + queued UART TX/RX); reads are combinational.
// MEMBUS_RX_FIFO_EN selects an RX FIFO; otherwise RX is a single holding byte. RX stalls its strobe while full.
module membus_mmio_ctrl #(
  parameter int RAM_AW  = 4,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  addr_hi,
  input  logic [7:0]  addr_lo,
  input  logic        rnw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  txdata,
  output logic        txclk,
  input  logic        txready,
  input  logic [7:0]  rxdata,
  output logic        rxclk,
  input  logic        rxready,
  output logic [7:0]  led
);

  localparam int RAM_N = 1 << RAM_AW;
  localparam int FD    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_GAP} tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_STROBE, RX_GAP} rx_st_t;

  logic [15:0] a;
  logic        is_rom, is_mmio, is_ram;
  logic        wr_tx, rd_rx, wr_st, wr_led;

  assign a        = {addr_hi, addr_lo};
  assign rom_addr = {addr_hi[6:0], addr_lo};
  assign is_rom   = addr_hi[7];
  assign is_mmio  = (addr_hi == 8'h7F);
  assign is_ram   = ~is_rom & ~is_mmio;
  assign wr_tx    = is_mmio & ~rnw & (addr_lo == 8'h00);
  assign rd_rx    = is_mmio &  rnw & (addr_lo == 8'h01);
  assign wr_st    = is_mmio & ~rnw & (addr_lo == 8'h02);
  assign wr_led   = is_mmio & ~rnw & (addr_lo == 8'h03);

  // RAM mirrors across the whole non-ROM, non-MMIO space
  logic [7:0] ram [RAM_N];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= 8'h00;
    end else if (is_ram && !rnw) begin
      ram[a[RAM_AW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       led <= 8'h00;
    else if (wr_led) led <= cpu_wdata;
  end

  // TX FIFO
  logic [7:0]         tx_mem [FD];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic [FIFO_AW:0]   tx_cnt;
  logic               tx_empty, tx_full, tx_push, tx_pop, tx_ovf;
  tx_st_t             tx_st, tx_nxt;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_push  = wr_tx & ~tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= cpu_wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
      txdata <= 8'h00;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) begin
        tx_rp  <= tx_rp + 1'b1;
        txdata <= tx_mem[tx_rp];
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (wr_tx && tx_full)            tx_ovf <= 1'b1;
      else if (wr_st && cpu_wdata[7])  tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) tx_st <= TX_IDLE;
    else       tx_st <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_st;
    tx_pop = 1'b0;
    txclk  = 1'b0;
    case (tx_st)
      TX_IDLE: begin
        if (!tx_empty && txready) begin
          tx_pop = 1'b1;
          tx_nxt = TX_STROBE;
        end
      end
      TX_STROBE: begin
        txclk  = 1'b1;
        tx_nxt = TX_GAP;
      end
      TX_GAP:  tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // RX storage
  logic       rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0] rx_head;
  rx_st_t     rx_st, rx_nxt;

  assign rx_pop = rd_rx & ~rx_empty;

`ifdef MEMBUS_RX_FIFO_EN
  logic [7:0]         rx_mem [FD];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic [FIFO_AW:0]   rx_cnt;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_head  = rx_mem[rx_rp];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rxdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_vld;

  assign rx_empty = ~rx_vld;
  assign rx_full  = rx_vld;
  assign rx_head  = rx_hold;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_hold <= 8'h00;
      rx_vld  <= 1'b0;
    end else if (rx_push) begin
      rx_hold <= rxdata;
      rx_vld  <= 1'b1;
    end else if (rx_pop) begin
      rx_vld  <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rx_st <= RX_IDLE;
    else       rx_st <= rx_nxt;
  end

  always_comb begin
    rx_nxt  = rx_st;
    rx_push = 1'b0;
    rxclk   = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        if (rxready && !rx_full) begin
          rx_push = 1'b1;
          rx_nxt  = RX_STROBE;
        end
      end
      RX_STROBE: begin
        rxclk  = 1'b1;
        rx_nxt = RX_GAP;
      end
      RX_GAP:  rx_nxt = RX_IDLE;
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata = 8'h00;
    if (rnw) begin
      if (is_rom) begin
        cpu_rdata = rom_data;
      end else if (is_mmio) begin
        case (addr_lo)
          8'h01:   cpu_rdata = rx_empty ? 8'h00 : rx_head;
          8'h02:   cpu_rdata = {tx_ovf, 3'b000, rx_full, rx_empty, tx_full, tx_empty};
          8'h03:   cpu_rdata = led;
          default: cpu_rdata = 8'h00;
        endcase
      end else begin
        cpu_rdata = ram[a[RAM_AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_membus_mmio_ctrl.sv
// Scoreboard bench for membus_mmio_ctrl: stimulus queues expected read data and TX bytes, a negedge monitor checks them.
module tb_membus_mmio_ctrl;

`ifdef MEMBUS_RX_FIFO_EN
  localparam int RXD = 4;
`else
  localparam int RXD = 1;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  addr_hi, addr_lo, cpu_wdata, cpu_rdata, rom_data;
  logic        rnw;
  logic [14:0] rom_addr;
  logic [7:0]  txdata, rxdata, led;
  logic        txclk, txready, rxclk, rxready;

  membus_mmio_ctrl #(.RAM_AW(4), .FIFO_AW(2)) dut (
    .clk(clk), .nrst(nrst), .addr_hi(addr_hi), .addr_lo(addr_lo), .rnw(rnw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rom_addr(rom_addr), .rom_data(rom_data),
    .txdata(txdata), .txclk(txclk), .txready(txready), .rxdata(rxdata), .rxclk(rxclk),
    .rxready(rxready), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [7:0]  rd;
    logic        chk_rom;
    logic [14:0] rom;
  } exp_t;

  exp_t       pq[$];
  exp_t       mon_e;
  logic [7:0] tx_q[$];
  int         tx_stamps[$];
  int         total = 0, bad = 0, cyc = 0, rx_pulses = 0;
  logic       probe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues
  always @(negedge clk) begin
    if (nrst && probe) begin
      if (pq.size() == 0) begin
        total++; bad++;
        $display("FAIL probe_queue: read probed with no expectation queued");
      end else begin
        mon_e = pq.pop_front();
        chk(mon_e.nm, 32'(cpu_rdata), 32'(mon_e.rd));
        if (mon_e.chk_rom) chk({mon_e.nm, "_romaddr"}, 32'(rom_addr), 32'(mon_e.rom));
      end
    end
    if (nrst && txclk) begin
      tx_stamps.push_back(cyc);
      if (tx_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected: txclk with txdata %0h, none expected", txdata);
      end else begin
        chk("txdata", 32'(txdata), 32'(tx_q.pop_front()));
      end
    end
    if (nrst && rxclk) rx_pulses++;
  end

  task automatic rd(input string nm, input logic [15:0] a, input logic r, input logic [7:0] exp,
                    input logic cr = 1'b0, input logic [14:0] rom = 15'h0);
    exp_t e;
    e.nm = nm; e.rd = exp; e.chk_rom = cr; e.rom = rom;
    {addr_hi, addr_lo} = a;
    rnw = r;
    pq.push_back(e);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
    rnw = 1'b1;
    {addr_hi, addr_lo} = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    {addr_hi, addr_lo} = a;
    cpu_wdata = d;
    rnw = 1'b0;
    @(posedge clk); #1;
    rnw = 1'b1;
    {addr_hi, addr_lo} = 16'h0000;
  endtask

  task automatic rx_one(input logic [7:0] d);
    rxdata = d;
    rxready = 1'b1;
    @(posedge clk); #1;
    rxready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int wc;

  initial begin
    addr_hi = 8'h00; addr_lo = 8'h00; rnw = 1'b1; cpu_wdata = 8'h00; rom_data = 8'h00;
    txready = 1'b0; rxready = 1'b0; rxdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txclk", 32'(txclk), 0);
    chk("rst_rxclk", 32'(rxclk), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_txdata", 32'(txdata), 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    rd("rst_status", 16'h7F02, 1'b1, 8'h05);
    rd("rst_led_rd", 16'h7F03, 1'b1, 8'h00);
    rd("rst_ram", 16'h0004, 1'b1, 8'h00);

    // RAM mirroring, write-cycle reads, ROM window
    wr(16'h0013, 8'h5A);
    rd("ram_0003", 16'h0003, 1'b1, 8'h5A);
    rd("ram_0103", 16'h0103, 1'b1, 8'h5A);
    rd("ram_7E03", 16'h7E03, 1'b1, 8'h5A);
    rom_data = 8'hC9;
    rd("rnw0_zero", 16'h9000, 1'b0, 8'h00);
    rd("rom_8123", 16'h8123, 1'b1, 8'hC9, 1'b1, 15'h0123);
    rd("mmio_unlisted", 16'h7F10, 1'b1, 8'h00);
    rd("txdata_rd", 16'h7F00, 1'b1, 8'h00);
    wr(16'h7F03, 8'h3C);
    chk("led_port", 32'(led), 32'h3C);
    rd("led_rd", 16'h7F03, 1'b1, 8'h3C);

    // Earliest transmit strobe: one cycle after the write edge
    txready = 1'b1;
    tx_stamps.delete();
    tx_q.push_back(8'h66);
    wr(16'h7F00, 8'h66);
    wc = cyc;
    repeat (5) @(posedge clk);
    #1;
    chk("tx_latency", (tx_stamps.size() > 0) ? 32'(tx_stamps[0] - wc) : 32'hFFFF, 1);

    // Overflow with txready low, then drain at 3 cycles per byte
    txready = 1'b0;
    tx_stamps.delete();
    wr(16'h7F00, 8'h11);
    wr(16'h7F00, 8'h22);
    wr(16'h7F00, 8'h33);
    wr(16'h7F00, 8'h44);
    wr(16'h7F00, 8'h55);
    rd("status_ovf_full", 16'h7F02, 1'b1, 8'h86);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    tx_q.push_back(8'h44);
    txready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("tx_pulse_count", 32'(tx_stamps.size()), 4);
    for (int i = 1; i < tx_stamps.size(); i++)
      chk("tx_period", 32'(tx_stamps[i] - tx_stamps[i-1]), 3);
    txready = 1'b0;
    rd("status_ovf_drained", 16'h7F02, 1'b1, 8'h85);
    wr(16'h7F02, 8'h80);
    rd("status_ovf_clr", 16'h7F02, 1'b1, 8'h05);

    // RX backpressure
    rx_pulses = 0;
    rxdata = 8'h31;
    rxready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rx_pulses_full", 32'(rx_pulses), 32'(RXD));
    rd("status_rx_full", 16'h7F02, 1'b1, 8'h09);
    rd("rx_pop_31", 16'h7F01, 1'b1, 8'h31);
    repeat (10) @(posedge clk);
    #1;
    chk("rx_pulses_refill", 32'(rx_pulses), 32'(RXD + 1));
    rxready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd("status_rx_refull", 16'h7F02, 1'b1, 8'h09);
    for (int i = 0; i < RXD; i++) rd("rx_drain", 16'h7F01, 1'b1, 8'h31);
    rd("rx_empty_rd", 16'h7F01, 1'b1, 8'h00);
    rd("status_rx_drained", 16'h7F02, 1'b1, 8'h05);

`ifdef MEMBUS_RX_FIFO_EN
    // Same-edge RX push and CPU pop at count 2
    rx_one(8'hA1);
    rx_one(8'hA2);
    rxdata = 8'hA3;
    rxready = 1'b1;
    rd("rx_same_pop", 16'h7F01, 1'b1, 8'hA1);
    rxready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd("status_cnt2", 16'h7F02, 1'b1, 8'h01);
    rd("rx_order_a2", 16'h7F01, 1'b1, 8'hA2);
    rd("rx_order_a3", 16'h7F01, 1'b1, 8'hA3);
    rd("status_after_order", 16'h7F02, 1'b1, 8'h05);
`else
    rx_one(8'hA1);
    rd("rx_hold_a1", 16'h7F01, 1'b1, 8'hA1);
`endif

    // Reset during the transmit strobe
    txready = 1'b1;
    wr(16'h7F00, 8'h77);
    @(posedge clk); #2;
    chk("strobe_before_rst", 32'(txclk), 1);
    nrst = 1'b0;
    #1;
    chk("strobe_async_drop", 32'(txclk), 0);
    chk("txdata_rst", 32'(txdata), 0);
    txready = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    rd("status_post_rst", 16'h7F02, 1'b1, 8'h05);
    rd("ram_cleared", 16'h0003, 1'b1, 8'h00);
    rd("led_cleared", 16'h7F03, 1'b1, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("tx_expect_left", 32'(tx_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
